uart_apb_responder: RTL

APB3 completer wrapping an 8N1 UART transmitter and receiver. It is the other end of the requester-side bridge: the requester issues APB3 reads and writes, and this block answers them through a four-register map. Serial tx_o/rx_i pins face the off-chip or loopback link. It is intended as the peripheral the Renode co-simulation requester talks to.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_responder_rx.sv | 112 +++++++++++
 rtl/uart_apb_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state types for the APB UART responder.
// Register offsets are word indices taken from paddr[3:2].
package uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_THR_FULL  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

endpackage

// File: rtl/uart_responder_rx.sv
// 8N1 receiver: two-flop synchroniser, mid-bit sampling FSM.
// byte_done_o / frame_err_o are single-cycle pulses; byte_o holds the last byte.
module uart_responder_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic        rx_en_i,
    input  logic [15:0] div_i,
    output logic [7:0]  byte_o,
    output logic        byte_done_o,
    output logic        frame_err_o
);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        fall;

    assign fall        = prev_q & ~sync2_q;
    assign byte_o      = shift_q;
    assign byte_done_o = done_q;
    assign frame_err_o = ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            div_q   <= MIN_DIV;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_en_i && fall) begin
                    state_d = RX_START;
                    div_d   = div_i;
                    cnt_d   = (div_i >> 1) - 16'd1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // A line that is high again at mid-start was a glitch
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = div_q - 16'd1;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    done_d  = sync2_q;
                    ferr_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_apb_responder.sv
// APB3 completer with four-register map around an 8N1 UART.
// Zero-wait-state: pready/prdata/pslverr are combinational in the access phase.
module uart_apb_responder
    import uart_pkg::*;
#(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32,
    parameter int DefaultDiv   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic                    tx_o,
    input  logic                    rx_i,
    output logic                    irq_o
);

    localparam logic [15:0] ResetDiv = 16'(DefaultDiv);

    logic        access, addr_err, thr_err, acc_err;
    logic        wr_ok, rd_ok, wr_data, rd_data;
    logic [1:0]  off;
    logic [15:0] rd16;

    logic [15:0] div_q, div_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [7:0]  thr_q, thr_d;
    logic        thr_full_q, thr_full_d;
    logic [7:0]  rbr_q, rbr_d;
    logic        rxv_q, rxv_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        irq_q;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;
    logic        tx_load, tx_busy;

    logic [7:0]  rx_byte;
    logic        rx_done, rx_ferr;
    logic        unused_bits;

    assign unused_bits = ^{pwdata[DataWidth-1:16], paddr[1:0]};

    assign off      = paddr[3:2];
    assign access   = psel & penable;
    assign addr_err = |paddr[AddressWidth-1:4];
    assign thr_err  = pwrite & (off == OFF_DATA) & thr_full_q;
    assign acc_err  = addr_err | thr_err;
    assign wr_ok    = access & pwrite & ~acc_err;
    assign rd_ok    = access & ~pwrite & ~acc_err;
    assign wr_data  = wr_ok & (off == OFF_DATA);
    assign rd_data  = rd_ok & (off == OFF_DATA);

    assign pready  = access;
    assign pslverr = access & acc_err;
    assign prdata  = rd_ok ? {{(DataWidth-16){1'b0}}, rd16} : '0;
    assign tx_o    = tx_q;
    assign irq_o   = irq_q;
    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        rd16 = '0;
        unique case (off)
            OFF_DATA:   rd16 = {8'h00, rbr_q};
            OFF_STATUS: begin
                rd16[ST_TX_BUSY]   = tx_busy;
                rd16[ST_THR_FULL]  = thr_full_q;
                rd16[ST_RX_VALID]  = rxv_q;
                rd16[ST_OVERRUN]   = ovr_q;
                rd16[ST_FRAME_ERR] = ferr_q;
            end
            OFF_DIV:    rd16 = div_q;
            OFF_CTRL:   rd16 = {13'd0, ctrl_q};
        endcase
    end

    uart_responder_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .rx_en_i     (ctrl_q[CTRL_RX_EN]),
        .div_i       (div_q),
        .byte_o      (rx_byte),
        .byte_done_o (rx_done),
        .frame_err_o (rx_ferr)
    );

    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        thr_d  = thr_q;
        rbr_d  = rbr_q;
        rxv_d  = rxv_q;
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (wr_ok) begin
            unique case (off)
                OFF_DATA:   thr_d = pwdata[7:0];
                OFF_STATUS: begin
                    if (pwdata[ST_OVERRUN])   ovr_d  = 1'b0;
                    if (pwdata[ST_FRAME_ERR]) ferr_d = 1'b0;
                end
                OFF_DIV:    div_d  = clamp_div(pwdata[15:0]);
                OFF_CTRL:   ctrl_d = pwdata[2:0];
            endcase
        end
        if (rd_data) rxv_d = 1'b0;
        // A read on the completion edge frees RBR, so the new byte lands
        if (rx_done) begin
            if (rxv_q && !rd_data) begin
                ovr_d = 1'b1;
            end else begin
                rbr_d = rx_byte;
                rxv_d = 1'b1;
            end
        end
        if (rx_ferr) ferr_d = 1'b1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        thr_full_d = thr_full_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: tx_load = thr_full_q & ctrl_q[CTRL_TX_EN];
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d   = '0;
                    tx_cnt_d   = tx_div_q - 16'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_load = thr_full_q & ctrl_q[CTRL_TX_EN];
                    if (!tx_load) tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase
        if (tx_load) begin
            tx_state_d = TX_START;
            tx_sh_d    = thr_q;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_d       = 1'b0;
            thr_full_d = 1'b0;
        end
        if (wr_data) thr_full_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= ResetDiv;
            ctrl_q     <= '0;
            thr_q      <= '0;
            thr_full_q <= 1'b0;
            rbr_q      <= '0;
            rxv_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= ResetDiv;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            rbr_q      <= rbr_d;
            rxv_q      <= rxv_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= ctrl_q[CTRL_RX_IRQ_EN] & (rxv_q | ovr_q | ferr_q);
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
        end
    end

endmodule
